// File: rtl/dsm_ctrl_pkg.sv
// rtl/dsm_ctrl_pkg.sv - shared types and default widths for the NCO sweep controller
//
// Contents:
//    ACC_FRAC_WIDTH_DEF / ACC_INT_WIDTH_DEF : default NCO step word split
//    DWELL_WIDTH_DEF                        : default dwell counter width
//    HOP_WIDTH                              : width of the saturating hop counter
//    sweep_state_t                          : controller state encoding
package dsm_ctrl_pkg;

   localparam int ACC_FRAC_WIDTH_DEF = 24;
   localparam int ACC_INT_WIDTH_DEF  = 8;
   localparam int DWELL_WIDTH_DEF    = 16;
   localparam int HOP_WIDTH          = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DWELL = 2'd2,
      ST_DONE  = 2'd3
   } sweep_state_t;

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - loadable down-counter that times the hold period of each hop
//
// Ports:
//    aclk        : clock, rising edge
//    arst_n      : asynchronous active-low reset, clears the count
//    clear       : synchronous clear (sweep abandoned)
//    load        : load load_value (takes priority over dec)
//    load_value  : value loaded, i.e. remaining hold cycles minus one
//    dec         : decrement by one, stopping at zero
//    zero        : count is zero
module dwell_timer #(
   parameter int DWELL_WIDTH = 16
) (
   input  logic                   aclk,
   input  logic                   arst_n,
   input  logic                   clear,
   input  logic                   load,
   input  logic [DWELL_WIDTH-1:0] load_value,
   input  logic                   dec,
   output logic                   zero
);

   localparam logic [DWELL_WIDTH-1:0] ONE = 1;

   logic [DWELL_WIDTH-1:0] count;

   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - ONE;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - frequency sweep sequencer feeding step words to an NCO
//
// Optional feature macro: NCO_SWEEP_BIDIR_EN (adds cfg_bidir, up/down ping-pong sweep)
//
// Ports:
//    aclk                : clock, rising edge
//    arst_n              : asynchronous active-low reset
//    cfg_start_step      : first step word of the sweep
//    cfg_stop_step       : inclusive upper step bound
//    cfg_delta           : unsigned increment per hop
//    cfg_dwell           : cycles held per hop after acceptance (0 behaves as 1)
//    cfg_continuous      : 1 = wrap and repeat, 0 = single sweep
//    cfg_bidir           : (macro only) reverse at the bounds instead of wrapping
//    start               : single-cycle sweep request, honoured only when idle
//    abort               : abandon the sweep, back to idle next cycle
//    m_axis_step_tdata   : step word to the NCO
//    m_axis_step_tvalid  : step word valid
//    m_axis_step_tready  : NCO accepts the step word
//    busy                : controller not idle
//    done                : one-cycle pulse when a single sweep completes
//    hop_count           : accepted step words since last start, saturating
module nco_sweep_ctrl
   import dsm_ctrl_pkg::*;
#(
   parameter int ACC_FRAC_WIDTH = ACC_FRAC_WIDTH_DEF,
   parameter int ACC_INT_WIDTH  = ACC_INT_WIDTH_DEF,
   parameter int DWELL_WIDTH    = DWELL_WIDTH_DEF,
   parameter int STEP_W         = ACC_FRAC_WIDTH + ACC_INT_WIDTH
) (
   input  logic                   aclk,
   input  logic                   arst_n,
   input  logic [STEP_W-1:0]      cfg_start_step,
   input  logic [STEP_W-1:0]      cfg_stop_step,
   input  logic [STEP_W-1:0]      cfg_delta,
   input  logic [DWELL_WIDTH-1:0] cfg_dwell,
   input  logic                   cfg_continuous,
`ifdef NCO_SWEEP_BIDIR_EN
   input  logic                   cfg_bidir,
`endif
   input  logic                   start,
   input  logic                   abort,
   output logic [STEP_W-1:0]      m_axis_step_tdata,
   output logic                   m_axis_step_tvalid,
   input  logic                   m_axis_step_tready,
   output logic                   busy,
   output logic                   done,
   output logic [HOP_WIDTH-1:0]   hop_count
);

   localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = 1;
   localparam logic [HOP_WIDTH-1:0]   HOP_ONE   = 1;
   localparam logic [HOP_WIDTH-1:0]   HOP_MAX   = '1;

   sweep_state_t state;

   logic [STEP_W-1:0]      cur;
   logic [STEP_W-1:0]      sh_start;
   logic [STEP_W-1:0]      sh_stop;
   logic [STEP_W-1:0]      sh_delta;
   logic [DWELL_WIDTH-1:0] sh_dwell;
   logic                   sh_cont;
   logic [HOP_WIDTH-1:0]   hops;

   logic                   handshake;
   logic                   dwell_zero;
   logic [DWELL_WIDTH-1:0] dwell_load;
   logic [STEP_W:0]        sum;
   logic                   up_ok;

   // Outcome of the hop decision taken when the dwell period expires.
   logic [STEP_W-1:0]      hop_cur;
   logic                   hop_end;

`ifdef NCO_SWEEP_BIDIR_EN
   logic                   sh_bidir;
   logic                   dir_down;
   logic                   hop_dir_down;
   logic [STEP_W:0]        diff;
   logic                   down_ok;
`endif

   // Abort wins over a same-cycle handshake: the word is not counted as taken.
   assign handshake  = (state == ST_LOAD) && m_axis_step_tready && !abort;
   assign dwell_load = (sh_dwell == '0) ? '0 : (sh_dwell - DWELL_ONE);

   // One extra bit catches wrap-around of the step word as an out-of-range hop.
   assign sum   = {1'b0, cur} + {1'b0, sh_delta};
   assign up_ok = !sum[STEP_W] && (sum[STEP_W-1:0] <= sh_stop);

`ifdef NCO_SWEEP_BIDIR_EN
   assign diff    = {1'b0, cur} - {1'b0, sh_delta};
   assign down_ok = !diff[STEP_W] && (diff[STEP_W-1:0] >= sh_start);
`endif

   always_comb begin
      hop_cur = cur;
      hop_end = 1'b0;
`ifdef NCO_SWEEP_BIDIR_EN
      hop_dir_down = dir_down;
      if (sh_bidir) begin
         if (!dir_down) begin
            if (up_ok) begin
               hop_cur = sum[STEP_W-1:0];
            end else if (down_ok) begin
               hop_cur      = diff[STEP_W-1:0];
               hop_dir_down = 1'b1;
            end else if (sh_cont) begin
               // Span too narrow to turn around in: just restart.
               hop_cur = sh_start;
            end else begin
               hop_end = 1'b1;
            end
         end else begin
            if (down_ok) begin
               hop_cur = diff[STEP_W-1:0];
            end else if (!sh_cont) begin
               hop_end = 1'b1;
            end else if (up_ok) begin
               hop_cur      = sum[STEP_W-1:0];
               hop_dir_down = 1'b0;
            end else begin
               hop_cur      = sh_start;
               hop_dir_down = 1'b0;
            end
         end
      end else
`endif
      begin
         if (up_ok) begin
            hop_cur = sum[STEP_W-1:0];
         end else if (sh_cont) begin
            hop_cur = sh_start;
         end else begin
            hop_end = 1'b1;
         end
      end
   end

   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         state    <= ST_IDLE;
         cur      <= '0;
         sh_start <= '0;
         sh_stop  <= '0;
         sh_delta <= '0;
         sh_dwell <= '0;
         sh_cont  <= 1'b0;
         hops     <= '0;
`ifdef NCO_SWEEP_BIDIR_EN
         sh_bidir <= 1'b0;
         dir_down <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  sh_start <= cfg_start_step;
                  sh_stop  <= cfg_stop_step;
                  sh_delta <= cfg_delta;
                  sh_dwell <= cfg_dwell;
                  sh_cont  <= cfg_continuous;
                  cur      <= cfg_start_step;
                  hops     <= '0;
`ifdef NCO_SWEEP_BIDIR_EN
                  sh_bidir <= cfg_bidir;
                  dir_down <= 1'b0;
`endif
                  state    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (handshake) begin
                  if (hops != HOP_MAX) begin
                     hops <= hops + HOP_ONE;
                  end
                  state <= ST_DWELL;
               end
            end
            ST_DWELL: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (dwell_zero) begin
                  if (hop_end) begin
                     state <= ST_DONE;
                  end else begin
                     cur   <= hop_cur;
`ifdef NCO_SWEEP_BIDIR_EN
                     dir_down <= hop_dir_down;
`endif
                     state <= ST_LOAD;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   dwell_timer #(
      .DWELL_WIDTH (DWELL_WIDTH)
   ) u_dwell_timer (
      .aclk       (aclk),
      .arst_n     (arst_n),
      .clear      (abort && (state != ST_IDLE)),
      .load       (handshake),
      .load_value (dwell_load),
      .dec        (state == ST_DWELL),
      .zero       (dwell_zero)
   );

   assign m_axis_step_tdata  = cur;
   assign m_axis_step_tvalid = (state == ST_LOAD);
   assign busy               = (state != ST_IDLE);
   assign done               = (state == ST_DONE);
   assign hop_count          = hops;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb/tb_nco_sweep_ctrl.sv - self-checking bench for nco_sweep_ctrl
module tb_nco_sweep_ctrl;

   localparam int SW = 32;
   localparam int DW = 16;

   logic          aclk = 1'b0;
   logic          arst_n = 1'b0;
   logic [SW-1:0] cfg_start_step = '0;
   logic [SW-1:0] cfg_stop_step = '0;
   logic [SW-1:0] cfg_delta = '0;
   logic [DW-1:0] cfg_dwell = '0;
   logic          cfg_continuous = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          m_axis_step_tready = 1'b1;
   logic [SW-1:0] m_axis_step_tdata;
   logic          m_axis_step_tvalid;
   logic          busy;
   logic          done;
   logic [15:0]   hop_count;

   int checks = 0;
   int errors = 0;

   nco_sweep_ctrl dut (
      .aclk               (aclk),
      .arst_n             (arst_n),
      .cfg_start_step     (cfg_start_step),
      .cfg_stop_step      (cfg_stop_step),
      .cfg_delta          (cfg_delta),
      .cfg_dwell          (cfg_dwell),
      .cfg_continuous     (cfg_continuous),
      .start              (start),
      .abort              (abort),
      .m_axis_step_tdata  (m_axis_step_tdata),
      .m_axis_step_tvalid (m_axis_step_tvalid),
      .m_axis_step_tready (m_axis_step_tready),
      .busy               (busy),
      .done               (done),
      .hop_count          (hop_count)
   );

   always #5 aclk = ~aclk;

   int            cyc = 0;
   logic [SW-1:0] acc_q[$];
   int            acc_t[$];
   logic [SW-1:0] exp_q[$];
   int            done_cnt = 0;
   int            stall_seen = 0;
   logic          prev_stall = 1'b0;
   logic [SW-1:0] prev_data = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(posedge aclk) cyc <= cyc + 1;

   // Observer at the falling edge: handshakes, done pulses, stall stability.
   always @(negedge aclk) begin
      if (arst_n) begin
         if (prev_stall)
            check("stall_hold", {31'd0, m_axis_step_tvalid, m_axis_step_tdata}, {31'd0, 1'b1, prev_data});
         if (m_axis_step_tvalid && m_axis_step_tready && !abort) begin
            acc_q.push_back(m_axis_step_tdata);
            acc_t.push_back(cyc);
         end
         if (m_axis_step_tvalid && !m_axis_step_tready && m_axis_step_tdata == 32'h0200_0000)
            stall_seen++;
         if (done) done_cnt++;
         prev_stall = m_axis_step_tvalid && !m_axis_step_tready && !abort;
         prev_data  = m_axis_step_tdata;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Expected word list of one pass of the sweep, from the arithmetic rule alone.
   task automatic build_model(input logic [SW-1:0] s, input logic [SW-1:0] p, input logic [SW-1:0] d);
      logic [63:0] w;
      logic [63:0] n;
      exp_q.delete();
      w = {32'd0, s};
      for (int i = 0; i < 64; i++) begin
         exp_q.push_back(w[SW-1:0]);
         n = w + {32'd0, d};
         if (n > {32'd0, p}) break;
         w = n;
      end
   endtask

   // mode 0: tready always 1; 1: random tready plus stray start pulses and
   // cfg noise; 2: hold tready low 3 cycles on the second word.
   // max_hops > 0 aborts once that many words were accepted.
   task automatic run_sweep(input logic [SW-1:0] s, input logic [SW-1:0] p, input logic [SW-1:0] d,
                            input logic [DW-1:0] dw, input logic cont, input int mode, input int max_hops);
      int n;
      int stall_n;
      acc_q.delete();
      acc_t.delete();
      done_cnt = 0;
      stall_seen = 0;
      stall_n = 0;
      build_model(s, p, d);
      @(posedge aclk); #1;
      cfg_start_step = s;
      cfg_stop_step = p;
      cfg_delta = d;
      cfg_dwell = dw;
      cfg_continuous = cont;
      m_axis_step_tready = 1'b1;
      start = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0;
      check("busy_after_start", {63'd0, busy}, 64'd1);
      check("tvalid_after_start", {63'd0, m_axis_step_tvalid}, 64'd1);
      n = 0;
      while (busy) begin
         if (mode == 1) begin
            cfg_start_step = $urandom;
            cfg_stop_step = $urandom;
            cfg_delta = $urandom;
            cfg_dwell = 16'($urandom_range(0, 5));
            cfg_continuous = 1'($urandom);
            start = ($urandom_range(0, 3) == 0);
            m_axis_step_tready = ($urandom_range(0, 3) != 0);
         end else if (mode == 2) begin
            if (acc_q.size() == 1 && m_axis_step_tvalid && stall_n < 3) begin
               m_axis_step_tready = 1'b0;
               stall_n++;
            end else begin
               m_axis_step_tready = 1'b1;
            end
         end
         if (max_hops > 0 && acc_q.size() >= max_hops) begin
            start = 1'b0;
            abort = 1'b1;
            @(posedge aclk); #1;
            abort = 1'b0;
            check("abort_tvalid", {63'd0, m_axis_step_tvalid}, 64'd0);
            check("abort_busy", {63'd0, busy}, 64'd0);
            break;
         end
         @(posedge aclk); #1;
         n++;
         if (n > 3000) begin
            check("sweep_timeout", 64'd1, 64'd0);
            abort = 1'b1;
            @(posedge aclk); #1;
            abort = 1'b0;
            break;
         end
      end
      start = 1'b0;
      m_axis_step_tready = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      check("busy_end", {63'd0, busy}, 64'd0);
      if (max_hops > 0) begin
         check("abort_no_done", done_cnt, 0);
         check("abort_hops_held", {48'd0, hop_count}, acc_q.size());
         for (int k = 0; k < acc_q.size(); k++)
            check($sformatf("cont_word%0d", k), acc_q[k], exp_q[k % exp_q.size()]);
      end else begin
         check("done_pulses", done_cnt, 1);
         check("hops", {48'd0, hop_count}, exp_q.size());
         check("word_count", acc_q.size(), exp_q.size());
         for (int k = 0; k < acc_q.size() && k < exp_q.size(); k++)
            check($sformatf("word%0d", k), acc_q[k], exp_q[k]);
      end
   endtask

   typedef struct {
      logic [SW-1:0] s;
      logic [SW-1:0] p;
      logic [SW-1:0] d;
      logic [DW-1:0] dw;
      int            exp_hops;
      logic [SW-1:0] exp_last;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int dwe;
      logic [SW-1:0] rs, rp, rd;
      logic rc;

      tbl[0] = '{32'h0100_0000, 32'h0300_0000, 32'h0100_0000, 16'd4, 3, 32'h0300_0000};
      tbl[1] = '{32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h0000_0080, 16'd1, 2, 32'hFFFF_FF80};
      tbl[2] = '{32'h0000_0500, 32'h0000_0100, 32'h0000_0007, 16'd2, 1, 32'h0000_0500};
      tbl[3] = '{32'd10,        32'd20,        32'd5,         16'd0, 3, 32'd20};
      tbl[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h4000_0000, 16'd3, 4, 32'hC000_0000};

      // reset state
      repeat (3) @(posedge aclk);
      #1;
      check("rst_tvalid", {63'd0, m_axis_step_tvalid}, 64'd0);
      check("rst_tdata", {32'd0, m_axis_step_tdata}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_hops", {48'd0, hop_count}, 64'd0);
      arst_n = 1'b1;
      repeat (2) @(posedge aclk);

      // table-driven single sweeps, tready always high
      for (int i = 0; i < 5; i++) begin
         run_sweep(tbl[i].s, tbl[i].p, tbl[i].d, tbl[i].dw, 1'b0, 0, 0);
         check($sformatf("tbl%0d_hops", i), {48'd0, hop_count}, tbl[i].exp_hops);
         check($sformatf("tbl%0d_last", i), {32'd0, m_axis_step_tdata}, {32'd0, tbl[i].exp_last});
         dwe = (tbl[i].dw == 0) ? 1 : int'(tbl[i].dw);
         for (int k = 1; k < acc_t.size(); k++)
            check($sformatf("tbl%0d_gap%0d", i, k), acc_t[k] - acc_t[k-1], dwe + 1);
      end

      // stall on the second word
      run_sweep(32'h0100_0000, 32'h0300_0000, 32'h0100_0000, 16'd4, 1'b0, 2, 0);
      check("stall_cycles", stall_seen, 3);
      check("stall_hops", {48'd0, hop_count}, 64'd3);

      // continuous 1,2,1,2... then abort
      run_sweep(32'd1, 32'd2, 32'd1, 16'd0, 1'b1, 0, 7);
      // zero delta repeats the start word until aborted, even in single mode
      run_sweep(32'd5, 32'd9, 32'd0, 16'd1, 1'b0, 0, 6);

      // abort together with start while idle
      @(posedge aclk); #1;
      start = 1'b1;
      abort = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0;
      abort = 1'b0;
      check("abort_start_busy", {63'd0, busy}, 64'd0);
      check("abort_start_tvalid", {63'd0, m_axis_step_tvalid}, 64'd0);

      // reset while a word is stalled on the bus
      done_cnt = 0;
      @(posedge aclk); #1;
      cfg_start_step = 32'h0100_0000;
      cfg_stop_step = 32'h0300_0000;
      cfg_delta = 32'h0100_0000;
      cfg_dwell = 16'd2;
      cfg_continuous = 1'b0;
      m_axis_step_tready = 1'b0;
      start = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0;
      check("pre_rst_tvalid", {63'd0, m_axis_step_tvalid}, 64'd1);
      @(negedge aclk); #2;
      arst_n = 1'b0;
      #1;
      check("async_rst_tvalid", {63'd0, m_axis_step_tvalid}, 64'd0);
      check("async_rst_tdata", {32'd0, m_axis_step_tdata}, 64'd0);
      check("async_rst_busy", {63'd0, busy}, 64'd0);
      check("async_rst_hops", {48'd0, hop_count}, 64'd0);
      repeat (2) @(posedge aclk);
      #1;
      arst_n = 1'b1;
      m_axis_step_tready = 1'b1;
      repeat (6) @(posedge aclk);
      #1;
      check("post_rst_done", done_cnt, 0);
      check("post_rst_busy", {63'd0, busy}, 64'd0);

      // randomized sweeps with random back-pressure and stray start pulses
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            rs = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
            rp = 32'hFFFF_FFFF - 32'($urandom_range(0, 8));
            rd = 32'($urandom_range(1, 8));
         end else begin
            rs = 32'($urandom_range(0, 20));
            rp = 32'($urandom_range(0, 30));
            rd = 32'($urandom_range(1, 5));
         end
         rc = 1'($urandom);
         build_model(rs, rp, rd);
         run_sweep(rs, rp, rd, 16'($urandom_range(0, 3)), rc, 1,
                   rc ? (exp_q.size() * 2 + $urandom_range(1, 3)) : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 Parameters SHALL be: ACC_FRAC_WIDTH, default 24, NCO fractional bits; ACC_INT_WIDTH, default 8, NCO integer bits; DWELL_WIDTH, default 16, dwell counter width; STEP_W = ACC_FRAC_WIDTH+ACC_INT_WIDTH (derived).
REQ-002 aclk  input  1  sole clock; all logic rising-edge.
REQ-003 arst_n  input  1  asynchronous active-low reset.
REQ-004 cfg_start_step  input  STEP_W  first NCO step word of the sweep.
REQ-005 cfg_stop_step  input  STEP_W  inclusive upper step bound.
REQ-006 cfg_delta  input  STEP_W  unsigned increment per hop.
REQ-007 cfg_dwell  input  DWELL_WIDTH  cycles held per hop after acceptance; 0 treated as 1.
REQ-008 cfg_continuous  input  1  1 = wrap to start and repeat; 0 = single sweep.
REQ-009 start  input  1  single-cycle sweep request.
REQ-010 abort  input  1  terminate sweep immediately.
REQ-011 m_axis_step_tdata  output  STEP_W  step word to NCO.
REQ-012 m_axis_step_tvalid  output  1  step word valid.
REQ-013 m_axis_step_tready  input  1  NCO accepts step word.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at single-sweep completion.
REQ-016 hop_count  output  16  accepted handshakes since last start, saturating at 0xFFFF.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, DWELL, DONE.
REQ-018 IDLE: start=1 and abort=0 latches all cfg_* into shadow registers, sets cur=cfg_start_step, clears hop_count, enters LOAD; tvalid high the cycle after start is sampled.
REQ-019 start SHALL be ignored when not IDLE; cfg_* changes mid-sweep SHALL have no effect.
REQ-020 LOAD: tvalid=1, tdata=cur, held stable until tready; on handshake, hop_count++ (saturating), dwell counter loads max(dwell,1)-1, enter DWELL.
REQ-021 DWELL: tvalid=0; counter decrements per cycle; at 0 compute next=cur+delta with carry bit (STEP_W+1 wide).
REQ-022 next <= stop and no carry: cur=next, enter LOAD; otherwise (exceeds stop or carry) continuous: cur=shadow start, enter LOAD; single: enter DONE.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; tdata retains last value.
REQ-024 start > stop: start word emitted once, then DONE (single) or repeated indefinitely (continuous).
REQ-025 delta=0: cur never advances; sweep repeats start word until abort.
REQ-026 abort in any non-IDLE state: IDLE next cycle, tvalid=0, no done pulse, hop_count held; abort with start in IDLE: abort wins.

Reset
REQ-027 arst_n low SHALL asynchronously force IDLE, tvalid=0, tdata=0, busy=0, done=0, hop_count=0, dwell counter=0, shadow registers=0.
REQ-028 Reset mid-handshake SHALL drop tvalid without completing the transfer; no done pulse follows.

Configuration
REQ-029 Macro NCO_SWEEP_BIDIR_EN defined: input cfg_bidir (1 bit, latched at start) added; when 1, on exceeding stop direction reverses, next=cur-delta, and on falling below start (or borrow) continuous reverses up again, single enters DONE.
REQ-030 Macro undefined: cfg_bidir port absent; up-sweep only per REQ-022.

Structure
REQ-031 Package dsm_ctrl_pkg SHALL hold the state enum typedef and the default width constants.
REQ-032 One sub-module dwell_timer (load, decrement, zero flag, DWELL_WIDTH param) SHALL implement the dwell counter.

Verification
REQ-033 start=0x0100_0000, stop=0x0300_0000, delta=0x0100_0000, dwell=4, single, tready=1 -> words 0x01,0x02,0x03 (<<24) accepted 5 cycles apart, done pulse, hop_count=3.
REQ-034 Same config, tready low 3 cycles on second word -> tdata stable 0x0200_0000 with tvalid high throughout stall, hop_count=3 at end.
REQ-035 Continuous, start=1, stop=2, delta=1, dwell=0 -> sequence 1,2,1,2,...; abort -> tvalid low next cycle, no done.
REQ-036 start=0xFFFF_FF00, stop=0xFFFF_FFFF, delta=0x80 -> 0xFFFF_FF00, 0xFFFF_FF80, then carry -> done, hop_count=2.
REQ-037 arst_n asserted while tvalid high -> all outputs 0 same cycle; start asserted during busy ignored.
REQ-038 With NCO_SWEEP_BIDIR_EN, start=1, stop=3, delta=1, bidir=1, single -> 1,2,3,2,1 then done, hop_count=5.
